// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Optional bypass path is selected in fetch_queue by FETCH_BYPASS_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEL_PC4    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JAL    = 2'd2,
        PC_SEL_JALR   = 2'd3
    } pc_sel_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a clear, used for both the {pc,instr} queue
// and the companion queue of in-flight request addresses.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: credit-limited in-order requests, prefetch FIFO,
// IF/ID register, redirect with stale-response dropping. Macro: FETCH_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter int              PC_SEL_WIDTH = 2,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_rsp_valid,
    input  logic [XLEN-1:0]         imem_rsp_data,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic [XLEN-1:0]         br_target,
    input  logic [XLEN-1:0]         jal_target,
    input  logic [XLEN-1:0]         jalr_target,
    input  logic                    stall_if,
    input  logic                    flush_if,
    output logic [XLEN-1:0]         pc_decode,
    output logic [XLEN-1:0]         instr_decode,
    output logic                    valid_decode
);

    localparam int              CW  = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   next_target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW:0]       in_use;
    logic              redirect;
    logic              req_fire;
    logic              rsp_keep;
    logic              bypass;

    logic [2*XLEN-1:0] entry_head;
    logic              entry_empty;
    logic              entry_full;
    logic [CW-1:0]     entry_count;
    logic [XLEN-1:0]   pc_head;
    logic              pc_empty;
    logic              pc_full;
    logic [CW-1:0]     pc_count;
    logic              unused_fifo_status;

    assign redirect       = (pc_sel != PC_SEL_WIDTH'(PC_SEL_PC4)) || flush_if;
    assign in_use         = {1'b0, entry_count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect && (in_use < (CW+1)'(DEPTH));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop == '0);

    // A response taken straight into IF/ID must not coincide with a redirect,
    // otherwise it would survive where the queued path discards it.
`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_keep && entry_empty && !stall_if && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign unused_fifo_status = ^{entry_full, pc_full, pc_empty, pc_count};

    always_comb begin
        next_target = pc;
        case (pc_sel)
            PC_SEL_WIDTH'(PC_SEL_BRANCH): next_target = br_target;
            PC_SEL_WIDTH'(PC_SEL_JAL):    next_target = jal_target;
            PC_SEL_WIDTH'(PC_SEL_JALR):   next_target = jalr_target;
            default:                      next_target = pc;
        endcase
    end

    // Responses still in flight at a redirect belong to the old path and
    // are counted into drop; the one arriving this cycle is already consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                pc   <= next_target;
                drop <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .clear     (redirect),
        .head      (pc_head),
        .full      (pc_full),
        .empty     (pc_empty),
        .count     (pc_count)
    );

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_entry_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep && !bypass),
        .push_data ({pc_head, imem_rsp_data}),
        .pop       (!flush_if && !stall_if),
        .clear     (redirect),
        .head      (entry_head),
        .full      (entry_full),
        .empty     (entry_empty),
        .count     (entry_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_decode    <= '0;
            instr_decode <= NOP;
            valid_decode <= 1'b0;
        end else if (flush_if) begin
            instr_decode <= NOP;
            valid_decode <= 1'b0;
        end else if (!stall_if) begin
            if (!entry_empty) begin
                pc_decode    <= entry_head[2*XLEN-1:XLEN];
                instr_decode <= entry_head[XLEN-1:0];
                valid_decode <= 1'b1;
            end else if (bypass) begin
                pc_decode    <= pc_head;
                instr_decode <= imem_rsp_data;
                valid_decode <= 1'b1;
            end else begin
                instr_decode <= NOP;
                valid_decode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with variable
// latency, scoreboard of expected IF/ID contents, redirect vector table.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [1:0]  pc_sel;
    logic [31:0] br_target;
    logic [31:0] jal_target;
    logic [31:0] jalr_target;
    logic        stall_if;
    logic        flush_if;
    logic [31:0] pc_decode;
    logic [31:0] instr_decode;
    logic        valid_decode;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN(32), .DEPTH(4), .PC_SEL_WIDTH(2), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_sel         (pc_sel),
        .br_target      (br_target),
        .jal_target     (jal_target),
        .jalr_target    (jalr_target),
        .stall_if       (stall_if),
        .flush_if       (flush_if),
        .pc_decode      (pc_decode),
        .instr_decode   (instr_decode),
        .valid_decode   (valid_decode)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] br;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic [31:0] exp_addr;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic        pre_req_valid;
    logic [31:0] pre_addr;
    logic [31:0] hold_pc;
    logic [31:0] got_pc;
    fq_entry_t   sb[$];
    mreq_t       mq[$];
    vec_t        vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory response, request capture, edge, IF/ID check.
    task automatic step();
        fq_entry_t e;
        logic      loaded;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst) mq.delete();
        else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        pre_req_valid = imem_req_valid;
        pre_addr      = imem_addr;
        if (rst || flush_if || pc_sel != PC_SEL_PC4) sb.delete();
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: pre_addr, due: cyc + lat});
            sb.push_back('{pc: pre_addr, instr: mem_word(pre_addr)});
        end
        loaded = !rst && !stall_if && !flush_if;
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            checkOutput("reset_valid", {31'd0, valid_decode}, 32'd0);
            checkOutput("reset_instr", instr_decode, NOP_INSTR);
            checkOutput("reset_pc_decode", pc_decode, 32'd0);
            checkOutput("reset_addr", imem_addr, 32'd0);
        end else if (loaded && valid_decode) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_decode: got pc %h, no instruction expected", pc_decode);
            end else begin
                e = sb.pop_front();
                checkOutput("decode_pc", pc_decode, e.pc);
                checkOutput("decode_instr", instr_decode, e.instr);
            end
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ready, input logic stall, input logic flush,
                                 input logic [1:0] sel, input int n);
        imem_req_ready = ready;
        stall_if       = stall;
        flush_if       = flush;
        pc_sel         = sel;
        for (int i = 0; i < n; i++) step();
        flush_if = 1'b0;
        pc_sel   = PC_SEL_PC4;
    endtask

    task automatic waitOutstanding(input string name);
        int k;
        k = 0;
        while (mq.size() < 2 && k < 20) begin
            applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 1);
            k++;
        end
        checkOutput(name, {31'd0, mq.size() >= 2}, 32'd1);
    endtask

    task automatic firstValidPc(input string name, input logic [31:0] exp);
        got_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 1);
            if (valid_decode) begin
                got_pc = pc_decode;
                break;
            end
        end
        checkOutput(name, got_pc, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{sel: PC_SEL_BRANCH, br: 32'h200, jal: 32'h111, jalr: 32'h222, exp_addr: 32'h200};
        vecs[1] = '{sel: PC_SEL_JAL,    br: 32'h333, jal: 32'h300, jalr: 32'h444, exp_addr: 32'h300};
        vecs[2] = '{sel: PC_SEL_JALR,   br: 32'h555, jal: 32'h666, jalr: 32'h404, exp_addr: 32'h404};
        vecs[3] = '{sel: PC_SEL_PC4,    br: 32'h777, jal: 32'h888, jalr: 32'h999, exp_addr: 32'h404};
        vecs[4] = '{sel: PC_SEL_BRANCH, br: 32'hFFFF_FFFC, jal: 32'h0, jalr: 32'h0, exp_addr: 32'hFFFF_FFFC};

        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pc_sel = PC_SEL_PC4; br_target = '0; jal_target = '0; jalr_target = '0;
        stall_if = 1'b0; flush_if = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        $display("[TB] streaming with 1-cycle memory");
        lat = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 1);
            checkOutput("stream_valid", {31'd0, valid_decode}, 32'd1);
        end

        $display("[TB] memory not ready");
        hold_pc = imem_addr;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, PC_SEL_PC4, 1);
            checkOutput("notready_req_valid", {31'd0, pre_req_valid}, 32'd1);
            checkOutput("notready_addr", imem_addr, hold_pc);
            if (i >= 3) begin
                checkOutput("bubble_valid", {31'd0, valid_decode}, 32'd0);
                checkOutput("bubble_instr", instr_decode, NOP_INSTR);
            end
        end

        $display("[TB] stall and release");
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 4);
        checkOutput("prestall_valid", {31'd0, valid_decode}, 32'd1);
        hold_pc = pc_decode;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, PC_SEL_PC4, 1);
            checkOutput("stall_pc_hold", pc_decode, hold_pc);
            checkOutput("stall_valid_hold", {31'd0, valid_decode}, 32'd1);
        end
        checkOutput("stall_credit_full", {31'd0, pre_req_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 1);
            checkOutput("release_valid", {31'd0, valid_decode}, 32'd1);
        end

        $display("[TB] JAL redirect with 3-cycle memory");
        lat = 3;
        waitOutstanding("jal_outstanding");
        jal_target = 32'h100;
        applyStimulus(1'b1, 1'b0, 1'b1, PC_SEL_JAL, 1);
        checkOutput("jal_no_req", {31'd0, pre_req_valid}, 32'd0);
        checkOutput("jal_addr", imem_addr, 32'h100);
        firstValidPc("jal_first_pc", 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 6);

        $display("[TB] flush without redirect");
        lat = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 5);
        hold_pc = pc_decode;
        applyStimulus(1'b1, 1'b0, 1'b1, PC_SEL_PC4, 1);
        checkOutput("flush_no_req", {31'd0, pre_req_valid}, 32'd0);
        checkOutput("flush_valid", {31'd0, valid_decode}, 32'd0);
        checkOutput("flush_instr", instr_decode, NOP_INSTR);
        checkOutput("flush_pc_hold", pc_decode, hold_pc);
        checkOutput("flush_addr_hold", imem_addr, pre_addr);
        firstValidPc("flush_resume_pc", pre_addr);

        $display("[TB] reset with requests outstanding");
        lat = 3;
        waitOutstanding("reset_outstanding");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 1);
        checkOutput("reset_no_req", {31'd0, pre_req_valid}, 32'd0);
        rst = 1'b0;
        firstValidPc("reset_first_pc", 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 6);

        $display("[TB] redirect target table");
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            br_target   = vecs[i].br;
            jal_target  = vecs[i].jal;
            jalr_target = vecs[i].jalr;
            applyStimulus(1'b0, 1'b0, 1'b1, vecs[i].sel, 1);
            checkOutput("table_no_req", {31'd0, pre_req_valid}, 32'd0);
            checkOutput("table_addr", imem_addr, vecs[i].exp_addr);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 1);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        firstValidPc("wrap_first_pc", 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, PC_SEL_PC4, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
